// File: rtl/bt_at_cmd_engine.sv
// bt_at_cmd_engine
// Sits between user logic and a UART_tx/UART_rx pair that talks to an HC-05 module.
// One command is held in an internal byte buffer. It is streamed out one byte per
// tx_start/tx_done handshake.
// - AT mode: after the last byte the engine captures the reply until TERM0,TERM1 is
//   seen. If rx stays silent for TIMEOUT_CYCLES, the stored command is replayed, up to
//   MAX_RETRIES times, and then the engine goes to ERR.
// - Data mode: the engine waits for bt_state before sending, and finishes in DONE.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   at_mode                1 = AT command/response, 0 = data stream (latched on launch)
//   cmd_data/valid/ready   byte load into the command buffer (IDLE only)
//   cmd_go, clear          launch a command / leave DONE or ERR and empty the buffer
//   bt_state               HC-05 link-up indicator
//   tx_start/data/done     UART_tx handshake
//   rx_data/valid          UART_rx byte strobe
//   rsp_data/valid/len     captured reply bytes, one-cycle strobe, saturating length
//   busy/done/error        status
//   retries                replays used by the current command
module bt_at_cmd_engine #(
    parameter int          DEPTH          = 64,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          MAX_RETRIES    = 2,
    parameter logic [7:0]  TERM0          = 8'h0D,
    parameter logic [7:0]  TERM1          = 8'h0A
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        at_mode,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_go,
    input  logic        clear,
    input  logic        bt_state,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_len,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  retries
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_LINK, S_SEND, S_WAIT_TX, S_RESP, S_DONE, S_ERR
    } state_t;

    state_t        r_state, w_next;
    logic [7:0]    r_buf [DEPTH];
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [TW-1:0] r_timer;
    logic          r_at;
    logic          r_term0_seen;   // previous captured byte was TERM0
    logic [7:0]    r_rsp_data;
    logic          r_rsp_valid;
    logic [15:0]   r_rsp_len;
    logic [3:0]    r_retries;

    logic          w_wr, w_launch, w_last, w_tmo, w_term, w_can_retry;
    logic [CW-1:0] w_eff_count;

    // A byte written in the same cycle as cmd_go counts toward the launch check.
    assign w_wr        = (r_state == S_IDLE) && cmd_valid && (r_count < CW'(DEPTH));
    assign w_eff_count = r_count + CW'(w_wr);
    assign w_launch    = (r_state == S_IDLE) && cmd_go && (w_eff_count != '0);
    assign w_last      = (CW'(r_rd_ptr) + CW'(1)) == r_count;
    assign w_tmo       = r_timer == TW'(TIMEOUT_CYCLES - 1);
    assign w_term      = rx_valid && (rx_data == TERM1) && r_term0_seen;
    assign w_can_retry = r_retries < 4'(MAX_RETRIES);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_launch) w_next = at_mode ? S_SEND : S_WAIT_LINK;
            S_WAIT_LINK: begin
                if (bt_state)   w_next = S_SEND;
                else if (w_tmo) w_next = S_ERR;
            end
            S_SEND:      w_next = S_WAIT_TX;
            S_WAIT_TX:   if (tx_done) w_next = w_last ? (r_at ? S_RESP : S_DONE) : S_SEND;
            S_RESP: begin
                // A byte arriving on the timeout cycle takes priority over the timeout.
                if (rx_valid) begin
                    if (w_term) w_next = S_DONE;
                end else if (w_tmo) begin
                    w_next = w_can_retry ? S_SEND : S_ERR;
                end
            end
            S_DONE, S_ERR: if (clear) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Buffer contents need no reset: r_count gates what is ever read.
    always_ff @(posedge clk) begin
        if (w_wr) r_buf[r_count[PW-1:0]] <= cmd_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_timer      <= '0;
            r_at         <= 1'b0;
            r_term0_seen <= 1'b0;
            r_rsp_data   <= 8'h00;
            r_rsp_valid  <= 1'b0;
            r_rsp_len    <= 16'h0000;
            r_retries    <= 4'h0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wr) r_count <= r_count + CW'(1);
                    if (w_launch) begin
                        r_at         <= at_mode;
                        r_rd_ptr     <= '0;
                        r_timer      <= '0;
                        r_retries    <= 4'h0;
                        r_rsp_len    <= 16'h0000;
                        r_term0_seen <= 1'b0;
                    end
                end
                S_WAIT_LINK: begin
                    if (!w_tmo) r_timer <= r_timer + TW'(1);
                end
                S_WAIT_TX: begin
                    if (tx_done) begin
                        if (w_last) begin
                            r_timer      <= '0;
                            r_rsp_len    <= 16'h0000;
                            r_term0_seen <= 1'b0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + PW'(1);
                        end
                    end
                end
                S_RESP: begin
                    if (rx_valid) begin
                        r_rsp_data   <= rx_data;
                        r_rsp_valid  <= 1'b1;
                        r_timer      <= '0;
                        r_term0_seen <= (rx_data == TERM0);
                        if (r_rsp_len != 16'hFFFF) r_rsp_len <= r_rsp_len + 16'd1;
                    end else if (w_tmo) begin
                        r_timer <= '0;
                        if (w_can_retry) begin
                            r_retries    <= r_retries + 4'd1;
                            r_rd_ptr     <= '0;
                            r_rsp_len    <= 16'h0000;
                            r_term0_seen <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    if (clear) begin
                        r_count   <= '0;
                        r_rd_ptr  <= '0;
                        r_retries <= 4'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    // tx_data is read straight from the buffer. rd_ptr and the buffer contents are frozen
    // while a byte is in flight, so the value stays stable until tx_done.
    assign tx_data   = (r_state == S_SEND || r_state == S_WAIT_TX) ? r_buf[r_rd_ptr] : 8'h00;
    assign tx_start  = (r_state == S_SEND);
    assign cmd_ready = (r_state == S_IDLE) && (r_count < CW'(DEPTH));
    assign busy      = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign done      = (r_state == S_DONE);
    assign error     = (r_state == S_ERR);
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;
    assign rsp_len   = r_rsp_len;
    assign retries   = r_retries;

endmodule

// File: tb/tb_bt_at_cmd_engine.sv
module tb_bt_at_cmd_engine;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        at_mode = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_go = 1'b0;
    logic        clear = 1'b0;
    logic        bt_state = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic [15:0] rsp_len;
    logic        busy, done, error;
    logic [3:0]  retries;

    int tests = 0;
    int fails = 0;

    bt_at_cmd_engine #(.DEPTH(64), .TIMEOUT_CYCLES(100), .MAX_RETRIES(2),
                       .TERM0(8'h0D), .TERM1(8'h0A)) dut (
        .clk(clk), .resetn(resetn), .at_mode(at_mode), .cmd_data(cmd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_go(cmd_go), .clear(clear),
        .bt_state(bt_state), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .rx_data(rx_data), .rx_valid(rx_valid), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .rsp_len(rsp_len), .busy(busy), .done(done), .error(error), .retries(retries)
    );

    always #5 clk = ~clk;

    // UART_tx stand-in: logs every tx_start byte and answers tx_done three cycles later.
    logic [7:0] tx_log[$];
    int tx_pulses = 0;
    int rsp_cnt   = 0;
    int tx_cnt    = 0;
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt = tx_cnt - 1;
            if (tx_cnt == 0) tx_done = 1'b1;
        end
        if (tx_start) begin
            tx_log.push_back(tx_data);
            tx_pulses = tx_pulses + 1;
            tx_cnt = 3;
        end
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] b);
        cmd_data  = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic go(input logic at);
        at_mode = at;
        cmd_go  = 1'b1;
        tick();
        cmd_go  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic wait_pulses(input string tag, input int n, input int max);
        int c = 0;
        while (tx_pulses < n && c < max) begin
            tick();
            c++;
        end
        chk(tag, tx_pulses, n);
    endtask

    task automatic wait_end(input string tag, input int max);
        int c = 0;
        while (!(done || error) && c < max) begin
            tick();
            c++;
        end
        chk(tag, {31'd0, done | error}, 32'd1);
    endtask

    initial begin
        int p0, r0;
        logic [7:0] at_cmd [4];
        at_cmd = '{8'h41, 8'h54, 8'h0D, 8'h0A};

        // ---- reset state
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, error}, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_rsp_len", rsp_len, 0);
        chk("rst_retries", retries, 0);
        resetn = 1'b1;
        tick();

        // ---- AT\r\n -> OK\r\n
        p0 = tx_pulses; r0 = rsp_cnt;
        for (int i = 0; i < 4; i++) load(at_cmd[i]);
        go(1'b1);
        wait_pulses("at_pulses", p0 + 4, 200);
        for (int i = 0; i < 4; i++) chk($sformatf("at_byte%0d", i), tx_log[p0 + i], at_cmd[i]);
        repeat (6) tick();
        chk("at_resp_busy", busy, 1);
        rx_byte(8'h4F); rx_byte(8'h4B); rx_byte(8'h0D);
        chk("at_not_done_yet", done, 0);
        rx_byte(8'h0A);
        chk("at_done", done, 1);
        chk("at_rsp_len", rsp_len, 4);
        chk("at_rsp_cnt", rsp_cnt - r0, 4);
        chk("at_rsp_data", rsp_data, 8'h0A);
        rx_byte(8'h55);  // outside RESP: must be ignored
        chk("ignored_rx_len", rsp_len, 4);
        chk("ignored_rx_cnt", rsp_cnt - r0, 4);
        do_clear();
        chk("clear_idle", {done, busy, cmd_ready}, 3'b001);

        // ---- go with empty buffer is ignored
        go(1'b1);
        tick();
        chk("empty_go", busy, 0);

        // ---- overflow: 65 bytes, 64 kept
        for (int i = 0; i < 64; i++) load(i[7:0]);
        chk("full_ready_low", cmd_ready, 0);
        load(8'hEE);
        p0 = tx_pulses;
        bt_state = 1'b1;
        go(1'b0);
        wait_end("full_end", 1000);
        chk("full_pulses", tx_pulses - p0, 64);
        chk("full_first", tx_log[p0], 8'h00);
        chk("full_last", tx_log[p0 + 63], 8'h3F);
        chk("full_done", done, 1);
        chk("full_rsp_len", rsp_len, 0);
        do_clear();

        // ---- AT timeout with replays
        p0 = tx_pulses;
        load(8'h41); load(8'h54);
        go(1'b1);
        wait_end("tmo_end", 2000);
        chk("tmo_error", error, 1);
        chk("tmo_retries", retries, 2);
        chk("tmo_pulses", tx_pulses - p0, 6);
        chk("tmo_replay_b4", tx_log[p0 + 4], 8'h41);
        chk("tmo_replay_b5", tx_log[p0 + 5], 8'h54);
        chk("tmo_busy", busy, 0);
        do_clear();
        chk("tmo_clear_retries", retries, 0);

        // ---- data mode, link comes up late
        p0 = tx_pulses;
        bt_state = 1'b0;
        load(8'h11); load(8'h22); load(8'h33);
        go(1'b0);
        repeat (50) tick();
        chk("link_wait_no_tx", tx_pulses - p0, 0);
        chk("link_wait_busy", busy, 1);
        bt_state = 1'b1;
        wait_end("link_end", 500);
        chk("link_done", done, 1);
        chk("link_pulses", tx_pulses - p0, 3);
        chk("link_b2", tx_log[p0 + 2], 8'h33);
        chk("link_rsp_len", rsp_len, 0);
        do_clear();

        // ---- data mode, link never comes up
        p0 = tx_pulses;
        bt_state = 1'b0;
        load(8'h77);
        go(1'b0);
        wait_end("nolink_end", 500);
        chk("nolink_error", error, 1);
        chk("nolink_no_tx", tx_pulses - p0, 0);
        chk("nolink_retries", retries, 0);
        do_clear();

        // ---- non-adjacent terminator
        p0 = tx_pulses;
        load(8'h41); load(8'h54);
        go(1'b1);
        wait_pulses("term_pulses", p0 + 2, 200);
        repeat (6) tick();
        rx_byte(8'h0D); rx_byte(8'h41); rx_byte(8'h0A);
        chk("term_split_no_done", done, 0);
        chk("term_split_len", rsp_len, 3);
        rx_byte(8'h0D); rx_byte(8'h0D);
        chk("term_dd_no_done", done, 0);
        rx_byte(8'h0A);
        chk("term_done", done, 1);
        chk("term_len", rsp_len, 6);
        do_clear();

        // ---- async reset during WAIT_TX
        p0 = tx_pulses;
        load(8'h01); load(8'h02); load(8'h03);
        go(1'b1);
        wait_pulses("rst_mid_pulse", p0 + 1, 50);
        chk("rst_mid_busy_before", busy, 1);
        resetn = 1'b0;
        #2;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_tx", {tx_start, tx_data}, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        chk("rst_mid_flags", {done, error, rsp_valid}, 0);
        tick();
        resetn = 1'b1;
        tick();
        go(1'b1);
        tick();
        chk("rst_mid_go_ignored", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
